fb_write_arbiter: RTL

//   Shares the single framebuffer write port (waddr/dout/write_en) between two

---
 rtl/fb_write_arbiter_if.sv | 51 +++++
 rtl/fb_write_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter_if
//  Description : Bundle of the two requester channels, the frame hold-off
//                input and the framebuffer write port of fb_write_arbiter.
//                master : requester / frame-source side (drives req/last/
//                         addr/data and frame_busy, observes grants and the
//                         write port)
//                slave  : the arbiter itself
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              last0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;

    logic              req1;
    logic              last1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;

    logic              frame_busy;

    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] dout;
    logic              write_en;
    logic              addr_err;

    modport master (
        output req0, last0, addr0, data0,
        output req1, last1, addr1, data1,
        output frame_busy,
        input  gnt0, gnt1,
        input  waddr, dout, write_en, addr_err
    );

    modport slave (
        input  req0, last0, addr0, data0,
        input  req1, last1, addr1, data1,
        input  frame_busy,
        output gnt0, gnt1,
        output waddr, dout, write_en, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter
//  Description : Round-robin burst arbiter sharing the framebuffer write port
//                between two requesters (req/gnt handshake). New grants are
//                held off while frame_busy is high so a frame being read out
//                is never torn; an active burst always runs to completion.
//  Ports       : clk_800k  sole clock, rising edge
//                nrst      asynchronous active-low reset
//                bus       fb_write_arbiter_if.slave
//                          req/last/addr/data/gnt x2, frame_busy,
//                          waddr/dout/write_en/addr_err
//  Revision    : 1.0  initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int ADDR_MAX  = 63,
    parameter int MAX_BURST = 16
) (
    input  wire logic          clk_800k,
    input  wire logic          nrst,
    fb_write_arbiter_if.slave  bus
);

    // Beat counter only needs to reach MAX_BURST-1.
    localparam int                c_cnt_w    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_BURST - 1);
    localparam logic [ADDR_W-1:0]  c_addr_max = ADDR_W'(ADDR_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prio;
    logic                w_prio_nxt;
    logic [c_cnt_w-1:0]  r_beat_cnt;
    logic [c_cnt_w-1:0]  w_beat_cnt_nxt;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_addr_ok;

    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_dout;
    logic                r_write_en;
    logic                r_addr_err;

    // ------------------------------------------------------------------
    // State, priority and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_800k or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_beat_cnt_nxt = r_beat_cnt;
        w_accept       = 1'b0;
        w_sel_addr     = bus.addr0;
        w_sel_data     = bus.data0;

        case (r_state)
            IDLE: begin
                if (!bus.frame_busy && (bus.req0 || bus.req1)) begin
                    w_beat_cnt_nxt = '0;
                    if (bus.req0 && bus.req1)
                        w_state_nxt = r_prio ? GRANT1 : GRANT0;
                    else if (bus.req0)
                        w_state_nxt = GRANT0;
                    else
                        w_state_nxt = GRANT1;
                end
            end

            GRANT0: begin
                if (!bus.req0) begin
                    w_state_nxt = IDLE;
                    w_prio_nxt  = 1'b1;
                end else begin
                    w_accept = 1'b1;
                    if (bus.last0 || (r_beat_cnt == c_cnt_last)) begin
                        w_state_nxt = IDLE;
                        w_prio_nxt  = 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            GRANT1: begin
                w_sel_addr = bus.addr1;
                w_sel_data = bus.data1;
                if (!bus.req1) begin
                    w_state_nxt = IDLE;
                    w_prio_nxt  = 1'b0;
                end else begin
                    w_accept = 1'b1;
                    if (bus.last1 || (r_beat_cnt == c_cnt_last)) begin
                        w_state_nxt = IDLE;
                        w_prio_nxt  = 1'b0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path: one cycle behind the accepted beat. An out-of-range beat
    // is dropped and flagged; waddr/dout keep the last real write.
    // ------------------------------------------------------------------
    assign w_addr_ok = (w_sel_addr <= c_addr_max);

    always_ff @(posedge clk_800k or negedge nrst) begin
        if (!nrst) begin
            r_waddr    <= '0;
            r_dout     <= '0;
            r_write_en <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_write_en <= w_accept && w_addr_ok;
            r_addr_err <= w_accept && !w_addr_ok;
            if (w_accept && w_addr_ok) begin
                r_waddr <= w_sel_addr;
                r_dout  <= w_sel_data;
            end
        end
    end

    assign bus.gnt0     = (r_state == GRANT0);
    assign bus.gnt1     = (r_state == GRANT1);
    assign bus.waddr    = r_waddr;
    assign bus.dout     = r_dout;
    assign bus.write_en = r_write_en;
    assign bus.addr_err = r_addr_err;

endmodule
`default_nettype wire
